instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port imem_req, output, 1, instruction-memory read request.
REQ-004 SHALL have port imem_addr, output, 32, byte address of the fetch, equal to pc.
REQ-005 SHALL have port imem_ack, input, 1, memory returns imem_rdata this cycle.
REQ-006 SHALL have port imem_rdata, input, 32, fetched instruction word.
REQ-007 SHALL have port instruction, output, 32, held instruction word to the decoder.
REQ-008 SHALL have port instr_valid, output, 1, instruction holds a fetched word.
REQ-009 SHALL have port instr_ready, input, 1, core retires instruction this cycle.
REQ-010 SHALL have ports Branch, Jump and JR, input, 1 each, decoder control for the held instruction.
REQ-011 SHALL have port br_cond, input, 1, ALU condition for the held instruction (1 = BLTZ taken).
REQ-012 SHALL have port jr_target, input, 32, rs register value.
REQ-013 SHALL have port pc, output, 32, address of the held or pending instruction.
REQ-014 SHALL have port retired, output, 16, count of retired instructions.
REQ-015 SHALL have port misalign, output, 1, sticky flag for a JR target with [1:0] != 0.

Function
REQ-016 FSM SHALL have states IDLE, REQ and HOLD.
REQ-017 IDLE SHALL advance to REQ unconditionally one cycle after reset release.
REQ-018 REQ SHALL drive imem_req=1 with imem_addr=pc stable until imem_ack.
REQ-019 On imem_ack in REQ, the fetch SHALL capture imem_rdata into instruction and enter HOLD; instr_valid SHALL rise the next cycle.
REQ-020 An imem_ack arriving outside REQ SHALL be ignored.
REQ-021 HOLD SHALL keep instr_valid=1 and instruction stable until instr_ready=1.
REQ-022 On instr_ready in HOLD, the fetch SHALL load pc<=next_pc, increment retired, deassert instr_valid and enter REQ.
REQ-023 next_pc SHALL be selected by priority:
- JR: {jr_target[31:2],2'b00}.
- Jump: {pc_plus4[31:28], instruction[25:0], 2'b00}.
- Branch&br_cond: pc_plus4 + (sign-extended instruction[15:0] << 2).
- Otherwise: pc_plus4.
REQ-024 Branch SHALL be ignored whenever Jump=1, because it is don't-care then.
REQ-025 All address arithmetic SHALL be 32-bit modulo 2^32; pc 0xFFFFFFFC+4 SHALL wrap to 0x00000000.
REQ-026 retired SHALL wrap from 0xFFFF to 0x0000.
REQ-027 misalign SHALL set on a retired JR with jr_target[1:0] != 0 and clear only on reset.
REQ-028 instr_ready SHALL be ignored outside HOLD.
REQ-029 Control inputs SHALL be sampled only on the retiring cycle.

Reset
REQ-030 While rst_n=0, outputs SHALL be: pc=0x00000000, instruction=0x00000000, state IDLE, imem_req=0, instr_valid=0, retired=0, misalign=0.
REQ-031 Reset mid-fetch SHALL abandon the request immediately; a later imem_ack SHALL be ignored.

Structure
REQ-032 Shared package cpu_pkg SHALL hold the fetch-state enum, RESET_PC=32'h0 and the opcode/funct constants used by the decoder.
REQ-033 Next-PC selection SHALL be a combinational sub-module pc_next_sel.

Verification
REQ-034 Reset, then ack after 2 wait cycles with rdata 0x20080005 (ADDI) and instr_ready -> imem_addr=0x0, instr_valid one cycle after ack, pc=0x4, retired=1.
REQ-035 At pc=0x10, BLTZ imm 0xFFFE with br_cond=1 -> pc=0x0C; with br_cond=0 -> pc=0x14.
REQ-036 At pc=0x40, J target 0x0000100 with Branch=X -> pc=0x00000400.
REQ-037 JR with jr_target=0x00000083 -> pc=0x00000080, misalign=1 and sticky.
REQ-038 instr_ready held low 5 cycles in HOLD -> instruction, pc and instr_valid stable, retired unchanged; stray imem_ack ignored.
REQ-039 rst_n low during REQ, then ack -> outputs reset, ack ignored, fetch restarts at 0x0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-state enum, reset PC and MIPS opcode/funct constants
package cpu_pkg;
  typedef enum logic [1:0] {FS_IDLE, FS_REQ, FS_HOLD} fetch_state_t;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] FUNCT_JR = 6'h08;
  localparam logic [4:0] RT_BLTZ = 5'h00;
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC priority select (JR > J > taken branch > pc+4)
// Ports: pc, instr_idx (instruction[25:0]), branch/jump/jr/br_cond controls,
//        jr_target (rs value) -> next_pc
module pc_next_sel (
  input  logic [31:0] pc,
  input  logic [25:0] instr_idx,
  input  logic        branch,
  input  logic        jump,
  input  logic        jr,
  input  logic        br_cond,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc
);
  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  always_comb begin
    pc_plus4 = pc + 32'd4;
    br_off = {{14{instr_idx[15]}}, instr_idx[15:0], 2'b00};
    // branch is only consulted when neither jump form applies
    next_pc = jr ? (jr_target & ~32'd3) :
              jump ? {pc_plus4[31:28], instr_idx, 2'b00} :
              (branch && br_cond) ? pc_plus4 + br_off : pc_plus4;
  end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: IDLE/REQ/HOLD instruction fetch with held word, retire counter and JR misalign flag
// Ports: clk, rst_n (async active-low); imem_req/imem_addr/imem_ack/imem_rdata memory side;
//        instruction/instr_valid/instr_ready decoder side; Branch/Jump/JR/br_cond/jr_target
//        controls for the held word; pc, retired, misalign status
module instr_fetch
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        JR,
  input  logic        br_cond,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [15:0] retired,
  output logic        misalign
);
  fetch_state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, instruction_q, instruction_d, next_pc;
  logic [15:0] retired_q, retired_d;
  logic misalign_q, misalign_d, retire;
  pc_next_sel u_pc_next_sel (
    .pc(pc_q),
    .instr_idx(instruction_q[25:0]),
    .branch(Branch),
    .jump(Jump),
    .jr(JR),
    .br_cond(br_cond),
    .jr_target(jr_target),
    .next_pc(next_pc)
  );
  always_comb begin
    retire = (state_q == FS_HOLD) && instr_ready;
    state_d = (state_q == FS_IDLE) ? FS_REQ :
              (state_q == FS_REQ) ? (imem_ack ? FS_HOLD : FS_REQ) :
              (instr_ready ? FS_REQ : FS_HOLD);
    instruction_d = (state_q == FS_REQ && imem_ack) ? imem_rdata : instruction_q;
    pc_d = retire ? next_pc : pc_q;
    retired_d = retired_q + {15'd0, retire};
    misalign_d = misalign_q | (retire & JR & (|jr_target[1:0]));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_IDLE;
      pc_q <= RESET_PC;
      instruction_q <= 32'h0;
      retired_q <= 16'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instruction_q <= instruction_d;
      retired_q <= retired_d;
      misalign_q <= misalign_d;
    end
  end
  assign imem_req = (state_q == FS_REQ);
  assign imem_addr = pc_q;
  assign instruction = instruction_q;
  assign instr_valid = (state_q == FS_HOLD);
  assign pc = pc_q;
  assign retired = retired_q;
  assign misalign = misalign_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed + random fetch/retire sequences against a behavioural PC model
module tb_instr_fetch;
  logic clk = 1'b0, rst_n = 1'b0;
  logic imem_req, imem_ack = 1'b0, instr_valid, instr_ready = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'h0, instruction, jr_target = 32'h0, pc;
  logic Branch = 1'b0, Jump = 1'b0, JR = 1'b0, br_cond = 1'b0, misalign;
  logic [15:0] retired;
  int errors = 0, checks = 0;
  logic [31:0] m_pc = 32'h0;
  logic [15:0] m_ret = 16'h0;
  logic m_mis = 1'b0;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction(instruction),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .Branch(Branch),
    .Jump(Jump), .JR(JR), .br_cond(br_cond), .jr_target(jr_target), .pc(pc),
    .retired(retired), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_ctl();
    Branch = 1'($urandom); Jump = 1'($urandom); JR = 1'($urandom);
    br_cond = 1'($urandom); jr_target = $urandom;
  endtask

  // reference next-PC from the architectural rules, in plain arithmetic
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ins,
      input logic br, input logic jp, input logic jrr, input logic cond, input logic [31:0] tgt);
    logic signed [31:0] imm;
    imm = $signed(ins[15:0]);
    if (jrr) return tgt - (tgt % 4);
    if (jp) return ((cur + 32'd4) & 32'hF000_0000) + (ins % 32'h0400_0000) * 4;
    if (br && cond) return cur + 32'd4 + 32'(imm * 4);
    return cur + 32'd4;
  endfunction

  // one full fetch: w wait cycles before ack, d stalled HOLD cycles before retire
  task automatic xact(input logic [31:0] r, input int w, input int d, input logic br,
      input logic jp, input logic jrr, input logic cond, input logic [31:0] tgt);
    chk("req_start", {31'd0, imem_req}, 32'd1);
    chk("addr_start", imem_addr, m_pc);
    for (int i = 0; i < w; i++) begin
      instr_ready = 1'($urandom);
      scramble_ctl();
      tick();
      chk("req_wait", {31'd0, imem_req}, 32'd1);
      chk("addr_wait", imem_addr, m_pc);
      chk("valid_wait", {31'd0, instr_valid}, 32'd0);
      chk("ret_wait", {16'd0, retired}, {16'd0, m_ret});
    end
    imem_ack = 1'b1;
    imem_rdata = r;
    instr_ready = 1'b1;
    tick();
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    imem_rdata = $urandom;
    chk("valid_after_ack", {31'd0, instr_valid}, 32'd1);
    chk("instr_capt", instruction, r);
    chk("req_hold", {31'd0, imem_req}, 32'd0);
    chk("ret_no_early", {16'd0, retired}, {16'd0, m_ret});
    for (int i = 0; i < d; i++) begin
      imem_ack = 1'b1;
      scramble_ctl();
      tick();
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("hold_instr", instruction, r);
      chk("hold_pc", pc, m_pc);
      chk("hold_ret", {16'd0, retired}, {16'd0, m_ret});
    end
    imem_ack = 1'b0;
    Branch = br; Jump = jp; JR = jrr; br_cond = cond; jr_target = tgt;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    scramble_ctl();
    m_pc = model_next(m_pc, r, br, jp, jrr, cond, tgt);
    m_ret = m_ret + 16'd1;
    if (jrr && (tgt % 4) != 0) m_mis = 1'b1;
    chk("retire_pc", pc, m_pc);
    chk("retire_cnt", {16'd0, retired}, {16'd0, m_ret});
    chk("retire_mis", {31'd0, misalign}, {31'd0, m_mis});
    chk("retire_valid", {31'd0, instr_valid}, 32'd0);
    chk("retire_req", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_instr"}, instruction, 32'h0);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_ret"}, {16'd0, retired}, 32'd0);
    chk({tag, "_mis"}, {31'd0, misalign}, 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    chk_reset_outs("rst");
    rst_n = 1'b1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("first_addr", imem_addr, 32'h0);
    // ADDI with 2 wait cycles and 5 stalled cycles (stray acks)
    xact(32'h2008_0005, 2, 5, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("addi_pc", pc, 32'h4);
    chk("addi_ret", {16'd0, retired}, 32'd1);
    repeat (3) xact($urandom & 32'h03FF_FFFF, 0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("at_0x10", pc, 32'h10);
    xact(32'h0400_FFFE, 1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("bltz_taken", pc, 32'h0C);
    xact(32'h2008_0001, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    xact(32'h0400_FFFE, 0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("bltz_not", pc, 32'h14);
    xact(32'h03E0_0008, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40);
    chk("jr_to_40", pc, 32'h40);
    xact(32'h0800_0100, 1, 0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
    chk("jump_400", pc, 32'h400);
    chk("mis_clear", {31'd0, misalign}, 32'd0);
    xact(32'h03E0_0008, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h83);
    chk("jr_misalign_pc", pc, 32'h80);
    chk("jr_misalign_flag", {31'd0, misalign}, 32'd1);
    xact(32'hFFFF_FFFF, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
    xact(32'h2008_0002, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("pc_wrap", pc, 32'h0);
    chk("mis_sticky", {31'd0, misalign}, 32'd1);
    for (int n = 0; n < 30; n++)
      xact($urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0), 1'($urandom), $urandom);
    // reset while a request is outstanding, ack arriving around the release
    tick();
    chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk_reset_outs("midrst_ack");
    rst_n = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'h0);
    chk("restart_valid", {31'd0, instr_valid}, 32'd0);
    chk("restart_instr", instruction, 32'h0);
    m_pc = 32'h0; m_ret = 16'h0; m_mis = 1'b0;
    xact(32'h2008_0005, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("restart_pc", pc, 32'h4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
